// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit (mult/multu/div/divu, optional madd/maddu).
// Optional accumulate ops enabled by defining MDU_MADD_EN.
`default_nettype none

module mult_div_unit #(
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYC - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b101;
  localparam logic [2:0] OP_MADDU = 3'b110;
`endif

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic [31:0]      a_q, b_q, hi_q, lo_q;
`ifdef MDU_MADD_EN
  logic [63:0]      acc_q;
`endif

  logic        op_ok, accept, commit, is_div;
  logic        sx_mul, neg_a, neg_b;
  logic [63:0] prod, result;
  logic [31:0] mag_a, mag_b, quo, rem;
  logic [63:0] div_res;

  always_comb begin
    op_ok = 1'b0;
    case (md_op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: op_ok = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU:                  op_ok = 1'b1;
`endif
      default:                            op_ok = 1'b0;
    endcase
  end

  assign accept = start && op_ok && (state_q == S_IDLE);
  assign is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy   = (state_q == S_RUN);
    commit = (state_q == S_RUN) && (cnt_q == '0);
  end

  // One shared 64-bit multiplier: signedness handled by the extension bits.
`ifdef MDU_MADD_EN
  assign sx_mul = (op_q == OP_MULT) || (op_q == OP_MADD);
`else
  assign sx_mul = (op_q == OP_MULT);
`endif
  assign prod = {{32{sx_mul & a_q[31]}}, a_q} * {{32{sx_mul & b_q[31]}}, b_q};

  // Signed divide runs on magnitudes; the overflow case falls out as 0x8000_0000 rem 0.
  assign neg_a = (op_q == OP_DIV) & a_q[31];
  assign neg_b = (op_q == OP_DIV) & b_q[31];
  assign mag_a = neg_a ? -a_q : a_q;
  assign mag_b = neg_b ? -b_q : b_q;
  assign quo   = mag_a / mag_b;
  assign rem   = mag_a % mag_b;

  always_comb begin
    if (b_q == '0) div_res = {a_q, 32'hFFFF_FFFF};
    else           div_res = {(neg_a ? -rem : rem), ((neg_a ^ neg_b) ? -quo : quo)};
  end

  always_comb begin
    result = '0;
    case (op_q)
      OP_MULT, OP_MULTU: result = prod;
      OP_DIV, OP_DIVU:   result = div_res;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: result = acc_q + prod;
`endif
      default:           result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
`ifdef MDU_MADD_EN
      acc_q <= '0;
`endif
    end else begin
      if (accept) begin
        cnt_q <= is_div ? DIV_LOAD : MUL_LOAD;
        op_q  <= md_op;
        a_q   <= rs_val;
        b_q   <= rt_val;
`ifdef MDU_MADD_EN
        acc_q <= {hi_q, lo_q};
`endif
      end else if (busy && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (commit) begin
        {hi_q, lo_q} <= result;
      end else if (!busy && !accept) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit.
`default_nettype none

module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val, wdata;
  logic        hi_we, lo_we;
  logic        busy;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  mult_div_unit #(.MUL_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op and count busy cycles (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    md_op = op; rs_val = a; rt_val = b; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; md_op = 3'b000; rs_val = '0; rt_val = '0;
    wdata = '0; hi_we = 1'b0; lo_we = 1'b0;
    tick(); tick();
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_hi", {32'b0, hi}, 64'd0);
    check("reset_lo", {32'b0, lo}, 64'd0);
    @(negedge clk); reset = 1'b1;
    tick();

    run_op(3'b001, 32'hFFFF_FFFE, 32'd3, cyc);
    check("mult_cycles", 64'(cyc), 64'd5);
    check("mult_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});

    run_op(3'b010, 32'hFFFF_FFFE, 32'd3, cyc);
    check("multu_cycles", 64'(cyc), 64'd5);
    check("multu_hilo", {hi, lo}, {32'h0000_0002, 32'hFFFF_FFFA});

    run_op(3'b011, 32'hFFFF_FFF9, 32'd2, cyc);
    check("div_cycles", 64'(cyc), 64'd10);
    check("div_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    run_op(3'b100, 32'd7, 32'd0, cyc);
    check("divu0_cycles", 64'(cyc), 64'd10);
    check("divu0_hilo", {hi, lo}, {32'h0000_0007, 32'hFFFF_FFFF});

    // Overflow divide with a second start during busy cycle 3.
    md_op = 3'b011; rs_val = 32'h8000_0000; rt_val = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 50) begin
      cyc++;
      if (cyc == 3) begin
        md_op = 3'b001; rs_val = 32'd5; rt_val = 32'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("divovf_cycles", 64'(cyc), 64'd10);
    check("divovf_hilo", {hi, lo}, {32'h0000_0000, 32'h8000_0000});
    tick();
    check("divovf_no_relaunch", {63'b0, busy}, 64'd0);

    // Unsupported op 111 ignored.
    md_op = 3'b111; start = 1'b1;
    tick();
    start = 1'b0;
    check("op111_busy", {63'b0, busy}, 64'd0);

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthilo", {hi, lo}, {32'h1234_5678, 32'h1234_5678});

    // mthi while busy ignored.
    md_op = 3'b001; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    hi_we = 1'b0;
    check("mthi_busy_hi", {32'b0, hi}, {32'b0, 32'h1234_5678});
    cyc = 0;
    while (busy && cyc < 50) begin cyc++; tick(); end
    check("mult34_hilo", {hi, lo}, {32'h0, 32'd12});

    // start + mtlo in the same idle cycle: start wins.
    md_op = 3'b001; rs_val = 32'd6; rt_val = 32'd7; start = 1'b1;
    lo_we = 1'b1; wdata = 32'hAAAA_5555;
    tick();
    start = 1'b0; lo_we = 1'b0;
    check("start_mtlo_lo_held", {32'b0, lo}, 64'd12);
    cyc = 0;
    while (busy && cyc < 50) begin cyc++; tick(); end
    check("start_mtlo_hilo", {hi, lo}, {32'h0, 32'd42});

    // Asynchronous reset at busy cycle 2 of a divide.
    md_op = 3'b011; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    check("rst_mid_busy", {63'b0, busy}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    #2 reset = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("rst_after_busy", {63'b0, busy}, 64'd0);
    check("rst_after_hilo", {hi, lo}, 64'd0);

    lo_we = 1'b1; wdata = 32'hFFFF_FFFF;
    tick();
    lo_we = 1'b0;
    check("preload_lo", {hi, lo}, {32'h0, 32'hFFFF_FFFF});
`ifdef MDU_MADD_EN
    run_op(3'b110, 32'd1, 32'd1, cyc);
    check("maddu_cycles", 64'(cyc), 64'd5);
    check("maddu_hilo", {hi, lo}, {32'h1, 32'h0});
`else
    md_op = 3'b110; rs_val = 32'd1; rt_val = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("maddu_off_busy", {63'b0, busy}, 64'd0);
    for (int i = 0; i < 6; i++) tick();
    check("maddu_off_hilo", {hi, lo}, {32'h0, 32'hFFFF_FFFF});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL expose these ports, clock and reset first:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  launch operation selected by md_op (E stage).
- md_op  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 madd, 110 maddu, 111 none.
- rs_val  input  32  operand A (forwarded rs).
- rt_val  input  32  operand B (forwarded rt).
- hi_we  input  1  mthi write strobe.
- lo_we  input  1  mtlo write strobe.
- wdata  input  32  mthi/mtlo data (forwarded rs).
- busy  output  1  operation in flight.
- hi  output  32  HI register; feeds mfhi writeback path to the register file.
- lo  output  32  LO register; feeds mflo writeback path to the register file.
REQ-002 Latency parameters SHALL be MUL_CYC (default 5: mult/multu/madd/maddu latency) and DIV_CYC (default 10: div/divu latency).

Function
REQ-003 start SHALL be accepted only when busy=0 and md_op is a supported op; operands and op SHALL be captured at that edge.
REQ-004 start while busy=1, or with an unsupported md_op, SHALL be ignored with no state change.
REQ-005 busy SHALL go 1 the cycle after acceptance and stay 1 for exactly MUL_CYC or DIV_CYC cycles.
REQ-006 HI/LO SHALL update on the edge where busy falls; new values visible the cycle busy reads 0.
REQ-007 FSM SHALL be IDLE -> RUN (down-counter loaded with latency-1) -> IDLE when counter=0 and HI/LO committed; no other states.
REQ-008 mult: {HI,LO} = signed 64-bit product; multu: unsigned 64-bit product.
REQ-009 div: LO = signed quotient truncated to zero, HI = remainder with dividend's sign; divu: unsigned equivalents.
REQ-010 Divide by zero SHALL give LO=32'hFFFF_FFFF, HI=dividend (div and divu).
REQ-011 div 32'h8000_0000 / 32'hFFFF_FFFF SHALL give LO=32'h8000_0000, HI=0.
REQ-012 hi_we/lo_we with busy=0 and no accepted start SHALL write wdata to HI/LO at that edge; both may assert together.
REQ-013 hi_we/lo_we while busy=1 SHALL be ignored.
REQ-014 start accepted in the same cycle as hi_we/lo_we: start SHALL win; the mthi/mtlo write is dropped.
REQ-015 hi/lo SHALL be driven directly from registers, not from in-flight results.

Reset
REQ-016 reset=0 SHALL immediately clear HI, LO, counter, captured operands and busy to 0, and force IDLE, including mid-operation.
REQ-017 An operation interrupted by reset SHALL never commit; the first edge after reset release MAY accept a start.

Configuration
REQ-018 Macro MDU_MADD_EN defined: md_op 101 (madd) SHALL give {HI,LO} += signed product, and 110 (maddu) {HI,LO} += unsigned product, both mod 2^64, using HI/LO as sampled at acceptance, latency MUL_CYC.
REQ-019 MDU_MADD_EN undefined: md_op 101/110 SHALL be unsupported per REQ-004 and no accumulate datapath SHALL be present.

Verification
REQ-020 mult rs=32'hFFFF_FFFE (-2), rt=3 -> busy high 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA; multu same operands -> HI=2, LO=32'hFFFF_FFFA.
REQ-021 div rs=-7, rt=2 -> busy 10 cycles; then LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; divu 7/0 -> LO=32'hFFFF_FFFF, HI=7.
REQ-022 div rs=32'h8000_0000, rt=-1 -> LO=32'h8000_0000, HI=0; a second start at busy cycle 3 is ignored (HI/LO and busy duration unchanged).
REQ-023 Idle, hi_we+lo_we with wdata=32'h1234_5678 -> both registers read 32'h1234_5678 next cycle; hi_we during busy -> HI unchanged; start+lo_we in same idle cycle -> LO holds only the product.
REQ-024 Assert reset=0 asynchronously at busy cycle 2 of a div -> busy, HI, LO read 0 before the next edge; after release, HI/LO remain 0 with no late commit.
REQ-025 With MDU_MADD_EN: HI=0, LO=32'hFFFF_FFFF, maddu rs=1, rt=1 -> HI=1, LO=0; without the macro the same md_op leaves busy=0 and HI/LO unchanged.
